// File: rtl/frame_load_sequencer.sv
// frame_load_sequencer: packs FIFO words into pixels and streams them into image memory,
// with watermark fetch throttling, abort and optional auto-reload.
module frame_load_sequencer #(
  parameter int DIN_W  = 16,
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 9,
  parameter int LVL_W  = 6,
  parameter int HI_WM  = 48,
  parameter int LO_WM  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              auto_reload,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              src_valid,
  input  logic [DIN_W-1:0]  src_data,
  output logic              src_ready,
  input  logic [LVL_W-1:0]  fill_level,
  output logic              fetch_pause,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_din,
  output logic              busy,
  output logic              done
);
  localparam int AW = PIX_W + DIN_W;
  localparam int CW = $clog2(AW + 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, pix_idx_q, pix_idx_d, mem_addr_q, mem_addr_d;
  logic [ADDR_W:0] len_q, len_d, rem_q, rem_d;
  logic [PIX_W-1:0] acc_q, acc_d, mem_din_q, mem_din_d;
  logic [CW-1:0] acc_n_q, acc_n_d, sum_n;
  logic [AW-1:0] ext;
  logic mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d, pause_q, pause_d;
  logic accept, full, emit, init, latch, flush;
  assign src_ready   = state_q == LOAD && rem_q != '0 && !abort;
  assign accept      = src_valid && src_ready;
  // new word lands directly above the bits already held
  assign ext         = AW'(acc_q) | (AW'(src_data) << acc_n_q);
  assign sum_n       = acc_n_q + CW'(DIN_W);
  assign full        = sum_n >= CW'(PIX_W);
  assign emit        = accept && full;
  assign fetch_pause = pause_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign busy        = busy_q;
  assign done        = done_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start && !abort ? LOAD : IDLE;
      LOAD:    state_d = abort ? IDLE : rem_q == '0 ? DONE : LOAD;
      default: state_d = !abort && auto_reload ? LOAD : IDLE;
    endcase
  end
  always_comb begin
    init      = state_d == LOAD && state_q != LOAD;
    latch     = init && state_q == IDLE;
    flush     = init || state_d != LOAD;
    base_d    = latch ? base_addr : base_q;
    len_d     = latch ? len : len_q;
    rem_d     = init ? len_d : emit ? rem_q - (ADDR_W+1)'(1) : rem_q;
    pix_idx_d = init ? '0 : emit ? pix_idx_q + ADDR_W'(1) : pix_idx_q;
    acc_d     = flush ? '0 : accept ? (full ? PIX_W'(ext >> PIX_W) : ext[PIX_W-1:0]) : acc_q;
    acc_n_d   = flush ? '0 : accept ? (full ? sum_n - CW'(PIX_W) : sum_n) : acc_n_q;
    mem_we_d  = emit;
    mem_addr_d = emit ? base_q + pix_idx_q : mem_addr_q;
    mem_din_d = emit ? ext[PIX_W-1:0] : mem_din_q;
    busy_d    = state_d == LOAD;
    done_d    = state_d == DONE;
    // hysteresis holds between the watermarks; a fresh load starts unpaused
    pause_d   = state_d != LOAD ? 1'b1 :
                fill_level >= LVL_W'(HI_WM) ? 1'b1 :
                init || fill_level <= LVL_W'(LO_WM) ? 1'b0 : pause_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      pix_idx_q  <= '0;
      acc_q      <= '0;
      acc_n_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pause_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      pix_idx_q  <= pix_idx_d;
      acc_q      <= acc_d;
      acc_n_q    <= acc_n_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pause_q    <= pause_d;
    end
  end
endmodule
